// File: rtl/heavy_part_table_dump.sv
// Heavy-part table readout: scans every bank entry once and forwards occupied entries to the report FIFO.
// Optional build macro DUMP_CLEAR_EN: zero each occupied entry as it is read back, making the dump destructive.
module heavy_part_table_dump #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 96,
    parameter int RD_LAT   = 2,
    parameter int MIN_VOTE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_done,
    output logic [ADDR_W:0]   entry_count,
    output logic              ram_rden,
    output logic [ADDR_W-1:0] ram_rdaddr,
    input  logic [DATA_W-1:0] ram_rdvalue,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [DATA_W-1:0] ram_wrvalue,
    output logic              entry_out_wr,
    output logic [DATA_W-1:0] entry_out,
    input  logic              entry_out_alf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [RD_LAT-1:0] tag_vld;
    logic              issue;
    logic              start_ok;
    logic              ret_vld;
    logic              occupied;
    logic              emit;

    // Flow control: a read is issued in any SCAN cycle where entry_out_alf is low.
    // The downstream FIFO keeps RD_LAT+1 words free while alf is low, so in-flight
    // reads always drain into it even after alf rises; there is no per-word ready.
    assign issue      = (state == SCAN) && !entry_out_alf;
    assign start_ok   = (state == IDLE) && dump_start;
    assign ram_rden   = issue;
    assign ram_rdaddr = issue ? addr : '0;
    assign dump_busy  = (state != IDLE);
    assign dump_done  = (state == DONE);

    assign ret_vld  = tag_vld[RD_LAT-1];
    assign occupied = ret_vld && (ram_rdvalue != '0);
    assign emit     = occupied && (ram_rdvalue[63:32] >= 32'(MIN_VOTE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (dump_start) state_nxt = SCAN;
            SCAN:  if (issue && (&addr)) state_nxt = DRAIN;
            DRAIN: if (tag_vld == '0) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // addr wraps to 0 after the last issue and is never reissued in DRAIN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr <= '0;
        end else if (start_ok) begin
            addr <= '0;
        end else if (issue) begin
            addr <= addr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_vld <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                tag_vld[i] <= tag_vld[i-1];
            end
            tag_vld[0] <= issue;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_out_wr <= 1'b0;
            entry_out    <= '0;
            entry_count  <= '0;
        end else begin
            entry_out_wr <= emit;
            if (emit) begin
                entry_out <= {ram_rdvalue[DATA_W-1:32], 32'd0};
            end
            if (start_ok) begin
                entry_count <= '0;
            end else if (emit) begin
                entry_count <= entry_count + 1'b1;
            end
        end
    end

`ifdef DUMP_CLEAR_EN
    // The address travels with the valid bit so the clear lands on the entry just read.
    logic [ADDR_W-1:0] tag_addr [RD_LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_addr[i] <= '0;
            end
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                tag_addr[i] <= tag_addr[i-1];
            end
            tag_addr[0] <= addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_wren   <= 1'b0;
            ram_wraddr <= '0;
        end else begin
            ram_wren <= occupied;
            if (occupied) begin
                ram_wraddr <= tag_addr[RD_LAT-1];
            end
        end
    end

    assign ram_wrvalue = '0;
`else
    assign ram_wren    = 1'b0;
    assign ram_wraddr  = '0;
    assign ram_wrvalue = '0;
`endif

endmodule

// File: tb/tb_heavy_part_table_dump.sv
// Bench for heavy_part_table_dump: RAM model plus a whole-table reference of which entries a scan reports.
module tb_heavy_part_table_dump;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 96;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BASE_DONE = DEPTH + RD_LAT + 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              dump_start;
    logic              dump_busy;
    logic              dump_done;
    logic [ADDR_W:0]   entry_count;
    logic              ram_rden;
    logic [ADDR_W-1:0] ram_rdaddr;
    logic [DATA_W-1:0] ram_rdvalue;
    logic              ram_wren;
    logic [ADDR_W-1:0] ram_wraddr;
    logic [DATA_W-1:0] ram_wrvalue;
    logic              entry_out_wr;
    logic [DATA_W-1:0] entry_out;
    logic              entry_out_alf;

    heavy_part_table_dump #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MIN_VOTE(1)
    ) dut (
        .clk(clk), .reset(reset), .dump_start(dump_start), .dump_busy(dump_busy),
        .dump_done(dump_done), .entry_count(entry_count), .ram_rden(ram_rden),
        .ram_rdaddr(ram_rdaddr), .ram_rdvalue(ram_rdvalue), .ram_wren(ram_wren),
        .ram_wraddr(ram_wraddr), .ram_wrvalue(ram_wrvalue), .entry_out_wr(entry_out_wr),
        .entry_out(entry_out), .entry_out_alf(entry_out_alf)
    );

    always #5 clk = ~clk;

    // RAM model: read data appears RD_LAT cycles after rden, garbage otherwise.
    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        for (int i = RD_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= ram_rden ? mem[ram_rdaddr] : {$urandom, $urandom, $urandom};
        if (ram_wren) mem[ram_wraddr] <= ram_wrvalue;
    end
    assign ram_rdvalue = rd_pipe[RD_LAT-1];

    logic [DATA_W-1:0] exp_q [$];
    int n_cmp = 0, n_err = 0;
    int ncyc = 0, base = 0;
    int rd_cnt, rd_err, exp_rd, done_cnt, done_cyc, busy_first, busy_last;
    int wr_cnt, win_emits, extra_emits, exp_cnt, occ_cnt;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        int rel;
        ncyc++;
        rel = ncyc - base;
        if (ram_rden) begin
            rd_cnt++;
            if (int'(ram_rdaddr) != exp_rd) rd_err++;
            exp_rd++;
        end
        if (entry_out_wr) begin
            if (entry_out_alf) win_emits++;
            if (exp_q.size() == 0) extra_emits++;
            else check("emit", entry_out, exp_q.pop_front());
        end
        if (dump_done) begin
            done_cnt++;
            done_cyc = rel;
        end
        if (dump_busy) begin
            if (busy_first < 0) busy_first = rel;
            busy_last = rel;
        end
        if (ram_wren) wr_cnt++;
    end

    // Reference: a scan reports every nonzero entry with pos vote >= 1, in address order.
    task automatic start_scan();
        exp_q.delete();
        exp_cnt = 0;
        occ_cnt = 0;
        for (int a = 0; a < DEPTH; a++) begin
            if (mem[a] != '0) begin
                occ_cnt++;
                if (mem[a][63:32] >= 32'd1) begin
                    exp_q.push_back({mem[a][95:32], 32'd0});
                    exp_cnt++;
                end
            end
        end
        rd_cnt = 0; rd_err = 0; exp_rd = 0; done_cnt = 0; done_cyc = -1;
        busy_first = -1; busy_last = -1; wr_cnt = 0; win_emits = 0; extra_emits = 0;
        @(negedge clk); #1;
        dump_start = 1'b1;
        base = ncyc;
        @(negedge clk); #1;
        dump_start = 1'b0;
    endtask

    task automatic finish_scan(input string tag, input int alf_at, input int alf_len, input int restart_at);
        int rel_now;
        for (int k = 0; k < 6000 && done_cnt == 0; k++) begin
            @(negedge clk); #1;
            rel_now = ncyc - base;
            entry_out_alf = (rel_now >= alf_at) && (rel_now < alf_at + alf_len);
            dump_start = (rel_now == restart_at);
        end
        entry_out_alf = 1'b0;
        dump_start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_cyc"}, done_cyc, BASE_DONE + alf_len);
        check({tag, "_busy_first"}, busy_first, 1);
        check({tag, "_busy_last"}, busy_last, BASE_DONE + alf_len);
        check({tag, "_reads"}, rd_cnt, DEPTH);
        check({tag, "_read_order_err"}, rd_err, 0);
        check({tag, "_missing_emits"}, exp_q.size(), 0);
        check({tag, "_extra_emits"}, extra_emits, 0);
        check({tag, "_entry_count"}, entry_count, exp_cnt);
`ifdef DUMP_CLEAR_EN
        check({tag, "_clear_writes"}, wr_cnt, occ_cnt);
        begin
            int left = 0;
            for (int a = 0; a < DEPTH; a++) if (mem[a] != '0) left++;
            check({tag, "_table_empty"}, left, 0);
        end
`else
        check({tag, "_clear_writes"}, wr_cnt, 0);
`endif
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, dump_busy, 0);
        check({tag, "_done"}, dump_done, 0);
        check({tag, "_count"}, entry_count, 0);
        check({tag, "_rden"}, {ram_rden, ram_rdaddr}, 0);
        check({tag, "_wr"}, {ram_wren, ram_wraddr, ram_wrvalue}, 0);
        check({tag, "_out"}, {entry_out_wr, entry_out}, 0);
    endtask

    task automatic fill_random(input int occ_pct, input int max_pos);
        for (int a = 0; a < DEPTH; a++) begin
            if ($urandom_range(99, 0) < occ_pct)
                mem[a] = {$urandom, 32'($urandom_range(max_pos, 0)), $urandom | 32'd1};
            else
                mem[a] = '0;
        end
    endtask

    initial begin
        for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;
        reset = 1'b0;
        dump_start = 1'b0;
        entry_out_alf = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Empty table: reads everything, reports nothing.
        start_scan();
        finish_scan("empty", -100, 0, -1);

        // Directed boundary entries, plus an occupied entry with zero pos vote.
        mem[12'h000] = {32'h1111_0000, 32'd5, 32'd7};
        mem[12'h7FF] = {32'h2222_7FF0, 32'd5, 32'd0};
        mem[12'hFFF] = {32'h3333_FFF0, 32'd5, 32'd3};
        mem[12'h100] = {32'h4444_1000, 32'd0, 32'd9};
        start_scan();
        finish_scan("directed", -100, 0, -1);
`ifdef DUMP_CLEAR_EN
        start_scan();
        finish_scan("second_dump", -100, 0, -1);
`endif

        // Every entry reportable, 10 cycles of almost-full mid-scan.
        fill_random(100, 3);
        for (int a = 0; a < DEPTH; a++) mem[a][63:32] = 32'($urandom_range(3, 1));
        start_scan();
        finish_scan("alf", 1000, 10, -1);
        check("alf_window_emits_le_3", win_emits <= RD_LAT + 1, 1);

        // Redundant start pulse mid-scan must be ignored.
        fill_random(50, 2);
        start_scan();
        finish_scan("restart", -100, 0, 100);

        // Reset mid-scan, then a fresh scan from address 0.
        fill_random(50, 2);
        start_scan();
        while ((ncyc - base) < 2000) @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        repeat (3) @(negedge clk);
        check("mid_reset_no_done", done_cnt, 0);
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        fill_random(60, 2);
        start_scan();
        finish_scan("after_reset", -100, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
